den1_src_reader: RTL

Read-side sequencer for the denoise stage-1 source buffer. On a start pulse it walks a run of buffer rows, each row being LENGTH packed samples of DATA_WIDTH bits, and streams the samples one per handshake to the downstream denoise engine. It sits between the source buffer's asynchronous read port (rd_addr in, row out) and the engine's sample input. It owns address generation, wrap-around, per-row and per-frame framing, and run completion.

---
 rtl/den1_src_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/den1_src_reader.sv
// den1_src_reader
//   Read-side sequencer for the denoise stage-1 source buffer. A start pulse
//   in IDLE launches a run of row_count rows beginning at base_addr, with the
//   row address wrapping from DEPTH-1 back to 0. Each row is read through the
//   buffer's combinational read port, captured into a shift register and then
//   streamed one sample per valid/ready handshake.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start             run request, only honoured in IDLE
//   base_addr         first row of the run (sampled with start)
//   row_count         number of rows in the run (sampled with start)
//   rd_addr           registered row address to the buffer read port
//   row_data          buffer row at rd_addr; sample k at [k*DATA_WIDTH +: DATA_WIDTH]
//   dout/dout_valid/dout_ready   sample stream to the denoise engine
//   dout_row_last     current sample is the last one of its row
//   dout_frame_last   current sample is the last one of the run
//   busy              run in progress (FETCH or SHIFT)
//   done              one-cycle pulse at run end
//   err               one-cycle pulse with done when the request was illegal
module den1_src_reader #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LENGTH     = 25,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  input  logic [ADDR_WIDTH-1:0]        row_count,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH*LENGTH-1:0] row_data,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         dout_row_last,
  output logic                         dout_frame_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int IDX_W = $clog2(LENGTH + 1);
  localparam int ROW_W = DATA_WIDTH * LENGTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ROW_W-1:0]      shreg;
  logic [IDX_W-1:0]      smp_idx;
  logic [ADDR_WIDTH-1:0] row_idx;
  logic [ADDR_WIDTH-1:0] rows_q;
  logic                  err_q;

  logic req_ok;
  logic xfer;
  logic last_smp;
  logic last_row;

  // Compared one bit wider so that DEPTH == 2**ADDR_WIDTH still works.
  assign req_ok   = (row_count != '0) &&
                    ({1'b0, row_count} <= CNT_W'(DEPTH)) &&
                    ({1'b0, base_addr} <  CNT_W'(DEPTH));
  assign xfer     = (state == S_SHIFT) && dout_ready;
  assign last_smp = (smp_idx == IDX_W'(LENGTH - 1));
  assign last_row = (row_idx == rows_q - ADDR_WIDTH'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = req_ok ? S_FETCH : S_DONE;
      S_FETCH: state_nxt = S_SHIFT;
      S_SHIFT: if (xfer && last_smp) state_nxt = last_row ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address, capture and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr <= '0;
      shreg   <= '0;
      smp_idx <= '0;
      row_idx <= '0;
      rows_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (req_ok) begin
              rd_addr <= base_addr;
              rows_q  <= row_count;
              row_idx <= '0;
              smp_idx <= '0;
              err_q   <= 1'b0;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          shreg   <= row_data;
          smp_idx <= '0;
        end
        S_SHIFT: begin
          if (xfer) begin
            // Zero fill keeps dout at 0 once the row has been drained.
            shreg   <= shreg >> DATA_WIDTH;
            smp_idx <= smp_idx + IDX_W'(1);
            if (last_smp && !last_row) begin
              rd_addr <= (rd_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                             : rd_addr + ADDR_WIDTH'(1);
              row_idx <= row_idx + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    dout_valid      = (state == S_SHIFT);
    dout            = dout_valid ? shreg[DATA_WIDTH-1:0] : '0;
    dout_row_last   = dout_valid && last_smp;
    dout_frame_last = dout_valid && last_smp && last_row;
    busy            = (state == S_FETCH) || (state == S_SHIFT);
    done            = (state == S_DONE);
    err             = (state == S_DONE) && err_q;
  end

endmodule
